bank_select_arbiter: RTL and testbench
======================================

BANK_SELECT_ARBITER -- requirements
Module: bank_select_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16: maximum consecutive GRANT cycles per owner, legal range 2..255.
REQ-002 Parameter CNT_W, default 8: hold-counter width; SHALL satisfy 2**CNT_W > MAX_HOLD.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  4  per-requester request; bit i is held high while requester i wants the bank.
REQ-006 done  input  4  per-requester completion pulse; only the bit of the current owner is honoured.
REQ-007 Cs  output  1  registered chip select to the 2-4 bank decoder; high only in GRANT.
REQ-008 A1  output  1  registered bank address MSB (owner index bit 1).
REQ-009 A0  output  1  registered bank address LSB (owner index bit 0).
REQ-010 gnt  output  4  registered one-hot grant; gnt[i] = Cs and {A1,A0}==i.
REQ-011 busy  output  1  high in GRANT and GAP states.
REQ-012 timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-013 FSM states: IDLE, GRANT, GAP; encoding per shared package.
REQ-014 IDLE: if any req bit is high, select winner by round-robin from pointer ptr, go to GRANT next edge; else stay.
REQ-015 Round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requesting index wins.
REQ-016 Latency: req sampled high in IDLE at edge n -> Cs, {A1,A0}, gnt valid after edge n+1.
REQ-017 GRANT: owner index frozen; Cs=1; hold counter increments each GRANT cycle starting at 1.
REQ-018 GRANT exits to GAP on the first of: done[owner]=1, req[owner]=0, or hold counter == MAX_HOLD.
REQ-019 Forced exit by hold limit alone SHALL pulse timeout for exactly the first GAP cycle; if done[owner] or req[owner] drop coincides, no timeout pulse.
REQ-020 done/req on non-owner bits SHALL be ignored during GRANT.
REQ-021 GAP lasts exactly one cycle: Cs=0, gnt=0, A1/A0 hold last owner, busy=1; ptr <= owner+1 mod 4 (3 wraps to 0); then IDLE.
REQ-022 Consequence: minimum 3-cycle turnaround between successive grants (GRANT end, GAP, IDLE arbitration); back-to-back same-owner grants are allowed only when no other index requests.
REQ-023 At most one gnt bit high in any cycle; gnt SHALL never change while Cs stays high.
REQ-024 Hold counter saturates at MAX_HOLD and clears on GRANT entry; no wrap.

Reset
REQ-025 rst high asynchronously forces: state IDLE, ptr=0, counter=0, Cs=0, A1=0, A0=0, gnt=0, busy=0, timeout=0.
REQ-026 rst mid-GRANT SHALL drop Cs/gnt immediately without passing through GAP; no timeout pulse.
REQ-027 First arbitration after rst release uses ptr=0 (index 0 highest priority).

Structure
REQ-028 Shared package bank_arb_pkg holds state encoding (IDLE=2'd0, GRANT=2'd1, GAP=2'd2), requester count 4, default MAX_HOLD.
REQ-029 One combinational sub-module rr_pick4 (inputs req[3:0], ptr[1:0]; outputs idx[1:0], any) performs the round-robin search.
REQ-030 All outputs come directly from flops; no combinational input-to-output path.

Verification
REQ-031 Single request: req=4'b0100 in IDLE -> next cycle Cs=1, {A1,A0}=2'b10, gnt=4'b0100; done[2] pulse -> GAP, then IDLE, ptr=3.
REQ-032 Fairness: req=4'b1111 held, each owner pulses done after 2 GRANT cycles -> grant order 0,1,2,3,0 with one GAP + one IDLE cycle between.
REQ-033 Timeout: MAX_HOLD=4, req=4'b0001 held, no done -> Cs high exactly 4 cycles, timeout pulses 1 cycle in GAP, re-grant to index 0.
REQ-034 Wrap-around: ptr=3 (after owner 2), req=4'b1001 -> index 3 granted; after release, ptr=0, index 0 granted next.
REQ-035 Reset mid-operation: rst asserted in 2nd GRANT cycle of index 1 -> Cs, gnt, busy 0 same cycle without clock edge; after release req=4'b1010 -> index 1 granted (ptr=0).
REQ-036 Non-owner noise: owner 0 in GRANT, done=4'b1110 pulsed -> grant unchanged; invariant checks for one-hot gnt and gnt consistency with Cs/A1/A0 every cycle.

Source files
------------

// File: rtl/bank_arb_pkg.sv
// rtl/bank_arb_pkg.sv - shared state encoding and sizing for the bank select arbiter
package bank_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int NUM_REQ          = 4;
  localparam int DEFAULT_MAX_HOLD = 16;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - round-robin search over four requesters starting at ptr
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Walk the search order backwards so the earliest requesting slot is written last and wins.
  always_comb begin
    idx  = 2'd0;
    any  = 1'b0;
    cand = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_select_arbiter.sv
// rtl/bank_select_arbiter.sv - round-robin owner selection for a 2-4 decoded bank with hold limit
module bank_select_arbiter
  import bank_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic               Cs,
  output logic               A1,
  output logic               A0,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               timeout
);

  arb_state_t       state, state_nxt;
  logic [1:0]       owner, owner_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       pick_idx;
  logic             pick_any;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
  logic             owner_release;
  logic             hold_hit;

  // The address pins double as the owner register; they hold the last owner outside GRANT.
  assign owner         = {A1, A0};
  assign owner_release = done[owner] | ~req[owner];
  assign hold_hit      = (cnt == CNT_W'(MAX_HOLD));

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    ptr_nxt     = ptr;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          state_nxt = ST_GRANT;
          owner_nxt = pick_idx;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (owner_release || hold_hit) begin
          state_nxt   = ST_GAP;
          timeout_nxt = hold_hit & ~owner_release;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_nxt = ST_IDLE;
        ptr_nxt   = owner + 2'd1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they change together with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      ptr     <= 2'd0;
      cnt     <= '0;
      Cs      <= 1'b0;
      A1      <= 1'b0;
      A0      <= 1'b0;
      gnt     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      Cs       <= (state_nxt == ST_GRANT);
      {A1, A0} <= owner_nxt;
      gnt      <= (state_nxt == ST_GRANT) ? (NUM_REQ'(1) << owner_nxt) : '0;
      busy     <= (state_nxt != ST_IDLE);
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bank_select_arbiter.sv
// tb/tb_bank_select_arbiter.sv - directed and randomized checks of bank_select_arbiter against a reference model
module tb_bank_select_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic       Cs, A1, A0, busy, timeout;
  logic [3:0] gnt;

  always #5 clk = ~clk;

  bank_select_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .Cs      (Cs),
    .A1      (A1),
    .A0      (A0),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: who owns the bank, how long they have held it, and whether a one-cycle gap is pending.
  bit m_active, m_gap, m_to;
  int m_owner, m_held, m_ptr;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_active = 0; m_gap = 0; m_to = 0;
    m_owner  = 0; m_held = 0; m_ptr = 0;
  endfunction

  function automatic void model_edge();
    bit rel, lim;
    m_to = 0;
    if (m_active) begin
      rel = done[m_owner] || !req[m_owner];
      lim = (m_held == MH);
      if (rel || lim) begin
        m_active = 0;
        m_gap    = 1;
        m_to     = lim && !rel;
      end else begin
        m_held++;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_ptr = (m_owner + 1) % 4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (req[(m_ptr + k) % 4]) begin
          m_active = 1;
          m_owner  = (m_ptr + k) % 4;
          m_held   = 1;
          break;
        end
      end
    end
  endfunction

  task automatic check_outputs();
    logic [1:0] mo;
    mo = 2'(m_owner);
    chk("cs", 8'(Cs), 8'(m_active));
    chk("addr", 8'({A1, A0}), 8'(mo));
    chk("gnt", 8'(gnt), m_active ? (8'd1 << mo) : 8'd0);
    chk("busy", 8'(busy), 8'(m_active || m_gap));
    chk("timeout", 8'(timeout), 8'(m_to));
    chk("gnt_onehot", 8'($countones(gnt) <= 1), 8'd1);
    chk("gnt_vs_cs_addr", 8'(gnt), Cs ? (8'd1 << {A1, A0}) : 8'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  logic [1:0] dut_log[$];
  logic [3:0] fair_exp;
  logic       prev_cs;
  logic       cs_hist[7];
  logic       to_hist[7];
  int         cs_cnt, to_cnt;

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // Single request to index 2, completion by done
    req = 4'b0100;
    step();
    chk("single_addr", 8'({A1, A0}), 8'd2);
    chk("single_gnt", 8'(gnt), 8'b0100);
    done = 4'b0100;
    step();
    chk("single_gap_cs", 8'(Cs), 8'd0);
    done = 4'b0000;
    req  = 4'b0000;
    step();
    chk("single_idle_busy", 8'(busy), 8'd0);

    // Pointer now 3: wrap-around order 3 then 0
    req = 4'b1001;
    step();
    chk("wrap_idx3", 8'({A1, A0}), 8'd3);
    req = 4'b0001;
    step();
    step();
    step();
    chk("wrap_idx0", 8'({A1, A0}), 8'd0);
    chk("wrap_idx0_cs", 8'(Cs), 8'd1);

    // Done on non-owner bits must not disturb owner 0
    done = 4'b1110;
    step();
    chk("noise_gnt", 8'(gnt), 8'b0001);
    done = 4'b0000;
    step();
    chk("noise_gnt_after", 8'(gnt), 8'b0001);
    req = 4'b0000;
    step(); step(); step();

    // Fairness: everybody requests, each owner finishes after two GRANT cycles
    do_reset();
    req = 4'b1111;
    prev_cs = 1'b0;
    dut_log.delete();
    for (int c = 0; c < 20; c++) begin
      done = (m_active && m_held == 2) ? (4'b0001 << m_owner) : 4'b0000;
      step();
      if (Cs && !prev_cs) dut_log.push_back({A1, A0});
      prev_cs = Cs;
    end
    done = 4'b0000;
    req  = 4'b0000;
    chk("fair_grants", 8'(dut_log.size()), 8'd5);
    for (int i = 0; i < 5 && i < dut_log.size(); i++) begin
      fair_exp = 4'(i % 4);
      chk($sformatf("fair_order%0d", i), 8'(dut_log[i]), 8'(fair_exp));
    end
    step(); step(); step();

    // Hold limit: a lone requester that never finishes
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      step();
      cs_hist[c] = Cs;
      to_hist[c] = timeout;
    end
    cs_cnt = 0;
    to_cnt = 0;
    for (int c = 0; c < 5; c++) cs_cnt += int'(cs_hist[c]);
    for (int c = 0; c < 7; c++) to_cnt += int'(to_hist[c]);
    chk("to_cs_cycles", 8'(cs_cnt), 8'd4);
    chk("to_pulse_in_gap", 8'(to_hist[4]), 8'd1);
    chk("to_pulse_count", 8'(to_cnt), 8'd1);
    chk("to_regrant", 8'(cs_hist[6]), 8'd1);
    chk("to_regrant_addr", 8'({A1, A0}), 8'd0);
    req = 4'b0000;
    step(); step(); step();

    // Reset during the second GRANT cycle of index 1
    do_reset();
    req = 4'b0010;
    step();
    step();
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mid_cs", 8'(Cs), 8'd0);
    chk("rst_mid_gnt", 8'(gnt), 8'd0);
    chk("rst_mid_busy", 8'(busy), 8'd0);
    chk("rst_mid_timeout", 8'(timeout), 8'd0);
    #1;
    rst = 1'b0;
    req = 4'b1010;
    step();
    chk("rst_after_idx1", 8'({A1, A0}), 8'd1);
    chk("rst_after_cs", 8'(Cs), 8'd1);
    req = 4'b0000;
    step(); step(); step();

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
